// File: rtl/elevator_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler_if
// Purpose  : Request / status bundle between the elevator scheduler and the
//            rest of the car controller (timer, call buttons, indicators).
// Revision : 1.0 - initial release
// ============================================================================
interface elevator_scheduler_if #(
  parameter int FLOORS = 4
);
  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;

  logic              clk_div;     // divided timer clock, every edge is a tick
  logic [FLOORS-1:0] req;         // hall/cab request bits
  logic              timer_hold;  // freezes the divider while the car is idle
  logic [FW-1:0]     floor;       // current car floor
  logic              dir_up;      // current or preferred direction
  logic              moving;      // car travelling between floors
  logic              door_open;   // door dwell in progress
  logic [FLOORS-1:0] pending;     // outstanding requests

  // Controller side: drives timer level and requests, observes car status
  modport master (
    output clk_div, req,
    input  timer_hold, floor, dir_up, moving, door_open, pending
  );

  // Scheduler side
  modport slave (
    input  clk_div, req,
    output timer_hold, floor, dir_up, moving, door_open, pending
  );
endinterface
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Purpose  : Latches floor requests and serves them in SCAN order, pacing car
//            travel and door dwell with ticks from the divided system timer.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_scheduler #(
  parameter int FLOORS       = 4,
  parameter int TRAVEL_TICKS = 1,
  parameter int DOOR_TICKS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_scheduler_if.slave  bus
);

  localparam int FW   = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int TMAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  // Counter value on which the next tick completes a floor step / door dwell
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_up_q, dir_up_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              clk_div_q;
  logic              moving_q;
  logic              door_open_q;
  logic              timer_hold_q;

  logic              w_tick;
  logic              w_above;
  logic              w_below;
  logic              w_ahead;
  logic              w_behind;
  logic [FW-1:0]     w_next_floor;
  logic [FLOORS-1:0] w_pend_in;
  logic [FLOORS-1:0] w_clear;

  // Any edge of the divided clock counts as one tick
  assign w_tick = bus.clk_div ^ clk_div_q;

  // Requests seen this cycle merged with the latched ones
  assign w_pend_in = pending_q | bus.req;

  // Floor the car reaches on its next step in the current direction
  assign w_next_floor = dir_up_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));

  // Latched requests on either side of the car
  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending_q[i]) begin
        if (i > int'(floor_q)) w_above = 1'b1;
        if (i < int'(floor_q)) w_below = 1'b1;
      end
    end
  end

  assign w_ahead  = dir_up_q ? w_above : w_below;
  assign w_behind = dir_up_q ? w_below : w_above;

  // SCAN sequencing: next state, floor, direction, tick count and clear mask
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_up_d = dir_up_q;
    tcnt_d   = tcnt_q;
    w_clear  = '0;

    case (state_q)
      ST_IDLE: begin
        // Ticks are ignored here; the timer is held anyway
        if (pending_q[floor_q]) begin
          state_d          = ST_DOOR;
          w_clear[floor_q] = 1'b1;
          tcnt_d           = '0;
        end else if (w_ahead) begin
          state_d = ST_MOVE;
          tcnt_d  = '0;
        end else if (w_behind) begin
          state_d  = ST_MOVE;
          dir_up_d = ~dir_up_q;
          tcnt_d   = '0;
        end
      end

      ST_MOVE: begin
        if (w_tick) begin
          if (tcnt_q == TRAVEL_LAST) begin
            tcnt_d = '0;
            if (!w_ahead) begin
              // Nothing left ahead: never step, so the car cannot leave the shaft
              state_d = ST_IDLE;
            end else begin
              floor_d = w_next_floor;
              // A request arriving in this very cycle also stops the car here
              if (w_pend_in[w_next_floor]) begin
                state_d               = ST_DOOR;
                w_clear[w_next_floor] = 1'b1;
              end
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      ST_DOOR: begin
        // Calls for the floor being served are absorbed into the open door
        w_clear[floor_q] = 1'b1;
        if (bus.req[floor_q]) begin
          tcnt_d = '0;
        end else if (w_tick) begin
          if (tcnt_q == DOOR_LAST) begin
            tcnt_d = '0;
            if (w_ahead) begin
              state_d = ST_MOVE;
            end else if (w_behind) begin
              state_d  = ST_MOVE;
              dir_up_d = ~dir_up_q;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end
    endcase

    pending_d = w_pend_in & ~w_clear;
  end

  // State registers plus status outputs decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      floor_q      <= '0;
      dir_up_q     <= 1'b1;
      pending_q    <= '0;
      tcnt_q       <= '0;
      clk_div_q    <= 1'b0;
      moving_q     <= 1'b0;
      door_open_q  <= 1'b0;
      timer_hold_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_up_q     <= dir_up_d;
      pending_q    <= pending_d;
      tcnt_q       <= tcnt_d;
      clk_div_q    <= bus.clk_div;
      moving_q     <= (state_d == ST_MOVE);
      door_open_q  <= (state_d == ST_DOOR);
      timer_hold_q <= (state_d == ST_IDLE);
    end
  end

  assign bus.floor      = floor_q;
  assign bus.dir_up     = dir_up_q;
  assign bus.moving     = moving_q;
  assign bus.door_open  = door_open_q;
  assign bus.timer_hold = timer_hold_q;
  assign bus.pending    = pending_q;

endmodule
`default_nettype wire
